uart_word_packer: RTL and testbench
===================================

# uart_word_packer

Receive-side stage placed directly downstream of the UART core's DataOut/DataOutValid/DataOutReady port. Collects consecutive UART bytes into one wide word and presents it on a valid/ready handshake to the host-command logic, such as an ORAM command or data FIFO. Byte order is little-endian: the first byte received lands in the least-significant position. An optional idle timeout discards partially assembled words after the serial line goes quiet.

## Interface
- ByteWidth, 8, width of each UART character.
- WordWidth, 64, width of the assembled output word. Must be an integer multiple of ByteWidth, with a ratio of at least 2.
- TimeoutCycles, 2000000, number of idle Clock cycles before a partial word is discarded. Used only with UART_PACK_TIMEOUT_EN.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- InData  in  ByteWidth  byte from the UART receiver.
- InValid  in  1  InData is valid.
- InReady  out  1  packer accepts InData this cycle.
- OutData  out  WordWidth  assembled word.
- OutValid  out  1  OutData holds a complete word.
- OutReady  in  1  consumer accepts OutData this cycle.
- Dropped  out  1  one-cycle pulse when a partial word is discarded.

## Operation
- N = WordWidth/ByteWidth. Count is a byte counter of width ceil(log2(N)), range 0..N-1.
- A byte is accepted when InValid && InReady.
- On acceptance, the byte is written into slot Count, bits [Count*ByteWidth +: ByteWidth] of the word register.
- Count increments on each accepted byte.
  - If Count == N-1 on acceptance, Count wraps to 0 and the state moves FILL -> FULL.
- States:
  - FILL: OutValid=0, InReady=1.
  - FULL: OutValid=1, InReady=OutReady.
- FULL -> FILL when OutReady=1 and no byte is accepted that cycle.
- Simultaneous events in FULL: if OutReady=1 and InValid=1 in the same cycle:
  - the word is delivered;
  - the new byte is accepted into slot 0;
  - Count becomes 1 and the state becomes FILL.
  - No bubble is inserted, and the delivered OutData is not corrupted by this write.
- Slots not yet rewritten keep stale data until overwritten. Every slot is rewritten before the next FULL, so no stale data is ever delivered.
- Reset mid-word or mid-FULL: Count=0, state FILL, and the word register is cleared. Any partial word and any undelivered word are lost, and Dropped is not pulsed.

## Timing
- Reset values: OutValid=0, OutData=0, InReady=1, Dropped=0.
- Latency: OutValid rises in the cycle after the N-th byte is accepted.
- OutData and OutValid come directly from registers; there is no combinational path from InData to OutData.
- InReady is combinational from OutReady only in FULL.
- While OutValid=1 and OutReady=0, OutData is held stable.
- Throughput: one byte per cycle sustained. No idle cycle between consecutive words when OutReady=1.

## Configuration
- UART_PACK_TIMEOUT_EN defined:
  - An idle counter clears on every accepted byte.
  - It increments each cycle while in FILL with Count>0.
  - When it reaches TimeoutCycles: Count returns to 0, the counter clears, and Dropped pulses high for exactly one cycle.
  - If a byte is accepted in the same cycle the timeout is reached, the byte wins: no drop occurs and the counter clears.
- UART_PACK_TIMEOUT_EN undefined: no timer logic is built, Dropped is tied to 0, and a partial word waits indefinitely.

## Structure
- Shared package uart_pkg holds:
  - the FILL/FULL state encoding;
  - a constant function clog2 for sizing Count and the idle counter;
  - the ByteWidth default of 8, shared with the UART core.
- One sub-module, uart_idle_timer:
  - parameter TimeoutCycles;
  - inputs Clear and Run;
  - output Expired, a one-cycle pulse.
  - Instantiated only under UART_PACK_TIMEOUT_EN.
- The word register and Count are handled in the top module.

## Test plan
- Basic word: with OutReady=1, bytes 0x01..0x08 one per cycle -> OutValid rises in the cycle after 0x08; OutData=64'h0807060504030201 for one cycle.
- Backpressure: OutReady=0 after a full word; offered ninth byte 0xAA -> InReady=0 and OutData held for 20 cycles. Raise OutReady -> word delivered and 0xAA accepted in the same cycle; Count=1.
- Back-to-back: 16 continuous bytes 0x10..0x1F with OutReady=1 -> two words, 64'h1716151413121110 then 64'h1F1E1D1C1B1A1918, with exactly 8 cycles between OutValid pulses.
- Reset mid-word: 5 bytes, then assert Reset low for 2 cycles, then 8 bytes 0xF0..0xF7 -> single word 64'hF7F6F5F4F3F2F1F0. Dropped stays 0.
- Timeout (UART_PACK_TIMEOUT_EN, TimeoutCycles=16): 3 bytes, then idle -> Dropped pulses once, 16 cycles after the last byte. The next 8 bytes 0x21..0x28 -> 64'h2827262524232221.
- Timeout race (UART_PACK_TIMEOUT_EN, TimeoutCycles=16): byte accepted exactly on cycle 16 -> no Dropped pulse, Count increments.

Source files
------------

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//
// Definitions shared by the UART core and its receive-side helpers.
//   BYTE_WIDTH   : default UART character width, shared with the UART core
//   pack_state_e : FILL/FULL state encoding of uart_word_packer
//   clog2()      : constant function used to size counters at elaboration
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned BYTE_WIDTH = 8;

    // FILL: collecting bytes; FULL: a complete word is offered downstream.
    typedef enum logic {
        PACK_FILL = 1'b0,
        PACK_FULL = 1'b1
    } pack_state_e;

    // Ceiling of log2(value); clog2(1) = 0, clog2(8) = 3, clog2(17) = 5.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// ----------------------------------------------------------------------------
// uart_idle_timer
//
// Counts idle cycles and signals when a partially assembled word has waited
// too long. Built only when UART_PACK_TIMEOUT_EN is defined.
//
// Ports:
//   Clock   in   system clock
//   Reset   in   asynchronous active-low reset
//   Clear   in   restart the idle count (a byte was accepted)
//   Run     in   count this cycle (partial word pending)
//   Expired out  one-cycle pulse on the TimeoutCycles-th consecutive idle cycle
// ----------------------------------------------------------------------------
module uart_idle_timer
    import uart_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 2000000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Clear,
    input  logic Run,
    output logic Expired
);

    localparam int unsigned IdleW    = clog2(TimeoutCycles + 1);
    localparam logic [IdleW-1:0] LastIdle = IdleW'(TimeoutCycles - 1);

    logic [IdleW-1:0] idle_q;
    logic [IdleW-1:0] idle_d;
    logic             expired;

    // idle_q holds the number of idle cycles already completed, so the
    // cycle in which it equals TimeoutCycles-1 is the TimeoutCycles-th one.
    // A simultaneous Clear (accepted byte) suppresses the expiry.
    always_comb begin
        expired = Run && !Clear && (idle_q == LastIdle);
        idle_d  = idle_q;
        if (Clear || expired) begin
            idle_d = '0;
        end else if (Run) begin
            idle_d = idle_q + IdleW'(1);
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end

    assign Expired = expired;

endmodule

// File: rtl/uart_word_packer.sv
// ----------------------------------------------------------------------------
// uart_word_packer
//
// Collects consecutive UART bytes into one WordWidth-bit word, little-endian
// (first byte in the least-significant slot), and offers the word on a
// valid/ready handshake.
//
// Build option: UART_PACK_TIMEOUT_EN -- when defined, a partial word that sits
// idle for TimeoutCycles cycles is discarded and Dropped pulses once. When
// undefined, no timer is built and Dropped is tied low.
//
// Ports:
//   Clock    in   system clock
//   Reset    in   asynchronous active-low reset
//   InData   in   byte from the UART receiver
//   InValid  in   InData valid
//   InReady  out  byte accepted this cycle when InValid is also high
//   OutData  out  assembled word (registered)
//   OutValid out  OutData holds a complete word (registered)
//   OutReady in   consumer takes OutData this cycle
//   Dropped  out  one-cycle pulse when a partial word is discarded
// ----------------------------------------------------------------------------
module uart_word_packer
    import uart_pkg::*;
#(
    parameter int unsigned ByteWidth     = BYTE_WIDTH,
    parameter int unsigned WordWidth     = 64,
    parameter int unsigned TimeoutCycles = 2000000
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [ByteWidth-1:0] InData,
    input  logic                 InValid,
    output logic                 InReady,
    output logic [WordWidth-1:0] OutData,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic                 Dropped
);

    localparam int unsigned Slots  = WordWidth / ByteWidth;
    localparam int unsigned CountW = clog2(Slots);
    localparam logic [CountW-1:0] LastSlot = CountW'(Slots - 1);

    pack_state_e          state_q;
    pack_state_e          state_d;
    logic [CountW-1:0]    count_q;
    logic [CountW-1:0]    count_d;
    logic [WordWidth-1:0] word_q;
    logic [WordWidth-1:0] word_d;
    logic [31:0]          slot_base;
    logic                 accept;
    logic                 last_byte;
    logic                 timeout;

    assign accept    = InValid && InReady;
    assign last_byte = (count_q == LastSlot);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= PACK_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // Leaving FULL only needs OutReady: if a byte arrives in the same
    // cycle it is the first byte of the next word and we are in FILL again.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            PACK_FILL: begin
                if (accept && last_byte) begin
                    state_d = PACK_FULL;
                end
            end
            PACK_FULL: begin
                if (OutReady) begin
                    state_d = PACK_FILL;
                end
            end
            default: state_d = PACK_FILL;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // In FULL a new byte may only enter while the held word leaves, so
    // InReady follows OutReady there.
    // ------------------------------------------------------------------
    always_comb begin
        InReady  = 1'b1;
        OutValid = 1'b0;
        case (state_q)
            PACK_FULL: begin
                InReady  = OutReady;
                OutValid = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Word register and byte counter
    // Count is 0 whenever the state is FULL, so a byte accepted during
    // delivery lands in slot 0. The delivered word was sampled by the
    // consumer before this edge, so overwriting slot 0 cannot corrupt it.
    // Slots are not cleared between words; each one is rewritten before
    // the next FULL.
    // ------------------------------------------------------------------
    always_comb begin
        slot_base = 32'(count_q) * ByteWidth;
        count_d   = count_q;
        word_d    = word_q;
        if (accept) begin
            word_d[slot_base +: ByteWidth] = InData;
            count_d = last_byte ? '0 : count_q + CountW'(1);
        end else if (timeout) begin
            count_d = '0;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            count_q <= '0;
            word_q  <= '0;
        end else begin
            count_q <= count_d;
            word_q  <= word_d;
        end
    end

    assign OutData = word_q;

`ifdef UART_PACK_TIMEOUT_EN
    uart_idle_timer #(
        .TimeoutCycles (TimeoutCycles)
    ) u_idle_timer (
        .Clock   (Clock),
        .Reset   (Reset),
        .Clear   (accept),
        .Run     ((state_q == PACK_FILL) && (count_q != '0)),
        .Expired (timeout)
    );

    assign Dropped = timeout;
`else
    // Without the timer a partial word waits indefinitely; TimeoutCycles
    // has no effect in this build.
    logic timeout_param_unused;
    assign timeout_param_unused = (TimeoutCycles != 0);
    assign timeout = 1'b0;
    assign Dropped = 1'b0;
`endif

endmodule

// File: tb/tb_uart_word_packer.sv
// ----------------------------------------------------------------------------
// tb_uart_word_packer
//
// Self-checking bench for uart_word_packer (ByteWidth=8, WordWidth=64,
// TimeoutCycles=16). Expected words are queued as bytes are driven; a
// monitor queues every word the DUT hands over, and each scenario task
// compares the two. Timeout scenarios run only when UART_PACK_TIMEOUT_EN
// is defined.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_word_packer;

    localparam int unsigned BW = 8;
    localparam int unsigned WW = 64;
    localparam int unsigned TO = 16;

    logic          Clock    = 1'b0;
    logic          Reset    = 1'b1;
    logic [BW-1:0] InData   = '0;
    logic          InValid  = 1'b0;
    logic          InReady;
    logic [WW-1:0] OutData;
    logic          OutValid;
    logic          OutReady = 1'b0;
    logic          Dropped;

    uart_word_packer #(
        .ByteWidth     (BW),
        .WordWidth     (WW),
        .TimeoutCycles (TO)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .InData   (InData),
        .InValid  (InValid),
        .InReady  (InReady),
        .OutData  (OutData),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Dropped  (Dropped)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    logic [WW-1:0] exp_q[$];
    logic [WW-1:0] obs_q[$];
    int            obs_cyc[$];
    int            drop_cnt = 0;
    int            drop_cyc = -1;

    int n_vec = 0;
    int n_bad = 0;

    // Monitor: record every handed-over word and every Dropped pulse.
    always @(negedge Clock) begin
        if (OutValid && OutReady) begin
            obs_q.push_back(OutData);
            obs_cyc.push_back(cyc);
        end
        if (Dropped === 1'b1) begin
            drop_cnt = drop_cnt + 1;
            drop_cyc = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Offer one byte and hold it until accepted; leaves InValid high so
    // consecutive calls stream one byte per cycle.
    task automatic send_byte(input logic [7:0] b, output int acc_cyc);
        bit ok;
        ok      = 1'b0;
        acc_cyc = -1;
        InData  = b;
        InValid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge Clock);
            if (InReady === 1'b1) begin
                ok      = 1'b1;
                acc_cyc = cyc;
            end
            @(posedge Clock);
            #1;
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_byte: byte %h never accepted, InReady=%b required 1", b, InReady);
        end
    endtask

    task automatic idle(input int n);
        InValid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        #2 Reset = 1'b0;
        repeat (2) @(negedge Clock);
        n_vec++;
        if (OutValid !== 1'b0) begin
            n_bad++; $display("FAIL reset_outvalid: got %b required 0", OutValid);
        end
        n_vec++;
        if (OutData !== 64'h0) begin
            n_bad++; $display("FAIL reset_outdata: got %h required 0", OutData);
        end
        n_vec++;
        if (InReady !== 1'b1) begin
            n_bad++; $display("FAIL reset_inready: got %b required 1", InReady);
        end
        n_vec++;
        if (Dropped !== 1'b0) begin
            n_bad++; $display("FAIL reset_dropped: got %b required 0", Dropped);
        end
        tick();
        Reset = 1'b1;
        tick();
    endtask

    task automatic test_basic_word();
        int            c;
        logic [WW-1:0] w;
        logic [WW-1:0] e;
        OutReady = 1'b1;
        for (int i = 0; i < 8; i++) send_byte(8'(i + 1), c);
        exp_q.push_back(64'h0807060504030201);
        InValid = 1'b0;
        @(negedge Clock);
        n_vec++;
        if (OutValid !== 1'b1 || cyc != c + 1) begin
            n_bad++; $display("FAIL basic_latency: OutValid=%b at cycle %0d, required 1 at cycle %0d", OutValid, cyc, c + 1);
        end
        n_vec++;
        if (OutData !== 64'h0807060504030201) begin
            n_bad++; $display("FAIL basic_data: got %h required 0807060504030201", OutData);
        end
        @(negedge Clock);
        n_vec++;
        if (OutValid !== 1'b0) begin
            n_bad++; $display("FAIL basic_one_cycle: OutValid=%b required 0", OutValid);
        end
        idle(2);
        n_vec++;
        if (obs_q.size() != 1) begin
            n_bad++; $display("FAIL basic_count: %0d words delivered, required 1", obs_q.size());
        end else begin
            w = obs_q.pop_front();
            e = exp_q.pop_front();
            void'(obs_cyc.pop_front());
            n_vec++;
            if (w !== e) begin
                n_bad++; $display("FAIL basic_scoreboard: got %h required %h", w, e);
            end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    endtask

    task automatic test_backpressure();
        int            c;
        int            bad;
        logic [WW-1:0] held;
        logic [WW-1:0] w;
        logic [WW-1:0] e;
        held     = 64'h3837363534333231;
        OutReady = 1'b0;
        for (int i = 0; i < 8; i++) send_byte(8'(8'h31 + i), c);
        exp_q.push_back(held);
        InData  = 8'hAA;
        InValid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            n_vec++;
            if (InReady !== 1'b0 || OutValid !== 1'b1 || OutData !== held) begin
                n_bad++;
                $display("FAIL bp_hold cycle %0d: InReady=%b OutValid=%b OutData=%h required 0 1 %h", i, InReady, OutValid, OutData, held);
            end
            tick();
        end
        OutReady = 1'b1;
        @(negedge Clock);
        n_vec++;
        if (InReady !== 1'b1 || OutValid !== 1'b1 || OutData !== held) begin
            n_bad++; $display("FAIL bp_release: InReady=%b OutValid=%b OutData=%h required 1 1 %h", InReady, OutValid, OutData, held);
        end
        tick();
        InValid = 1'b0;
        @(negedge Clock);
        n_vec++;
        if (OutValid !== 1'b0) begin
            n_bad++; $display("FAIL bp_no_bubble_repeat: OutValid=%b required 0", OutValid);
        end
        tick();
        // 0xAA took slot 0, so seven more bytes complete the next word.
        for (int i = 0; i < 7; i++) send_byte(8'(8'hB1 + i), c);
        exp_q.push_back(64'hB7B6B5B4B3B2B1AA);
        idle(3);
        n_vec++;
        if (obs_q.size() != 2) begin
            n_bad++; $display("FAIL bp_count: %0d words delivered, required 2", obs_q.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                w = obs_q.pop_front();
                e = exp_q.pop_front();
                n_vec++;
                if (w !== e) begin
                    n_bad++; $display("FAIL bp_word%0d: got %h required %h", k, w, e);
                end
            end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    endtask

    task automatic test_back_to_back();
        int            c;
        int            first;
        logic [WW-1:0] w;
        logic [WW-1:0] e;
        int            c0;
        int            c1;
        OutReady = 1'b1;
        first    = -1;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(8'h10 + i), c);
            if (i == 0) first = c;
        end
        exp_q.push_back(64'h1716151413121110);
        exp_q.push_back(64'h1F1E1D1C1B1A1918);
        idle(3);
        n_vec++;
        if (c - first != 15) begin
            n_bad++; $display("FAIL b2b_throughput: 16 bytes took %0d cycles, required 15", c - first);
        end
        n_vec++;
        if (obs_q.size() != 2) begin
            n_bad++; $display("FAIL b2b_count: %0d words delivered, required 2", obs_q.size());
        end else begin
            c0 = obs_cyc.pop_front();
            c1 = obs_cyc.pop_front();
            n_vec++;
            if (c1 - c0 != 8) begin
                n_bad++; $display("FAIL b2b_spacing: %0d cycles between words, required 8", c1 - c0);
            end
            for (int k = 0; k < 2; k++) begin
                w = obs_q.pop_front();
                e = exp_q.pop_front();
                n_vec++;
                if (w !== e) begin
                    n_bad++; $display("FAIL b2b_word%0d: got %h required %h", k, w, e);
                end
            end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    endtask

    task automatic test_reset_mid_word();
        int            c;
        int            base;
        logic [WW-1:0] w;
        logic [WW-1:0] e;
        base     = drop_cnt;
        OutReady = 1'b1;
        for (int i = 0; i < 5; i++) send_byte(8'(8'h51 + i), c);
        InValid = 1'b0;
        Reset   = 1'b0;
        @(negedge Clock);
        n_vec++;
        if (OutValid !== 1'b0 || OutData !== 64'h0 || Dropped !== 1'b0) begin
            n_bad++; $display("FAIL midreset_state: OutValid=%b OutData=%h Dropped=%b required 0 0 0", OutValid, OutData, Dropped);
        end
        tick();
        tick();
        Reset = 1'b1;
        for (int i = 0; i < 8; i++) send_byte(8'(8'hF0 + i), c);
        exp_q.push_back(64'hF7F6F5F4F3F2F1F0);
        idle(3);
        n_vec++;
        if (obs_q.size() != 1) begin
            n_bad++; $display("FAIL midreset_count: %0d words delivered, required 1", obs_q.size());
        end else begin
            w = obs_q.pop_front();
            e = exp_q.pop_front();
            n_vec++;
            if (w !== e) begin
                n_bad++; $display("FAIL midreset_word: got %h required %h", w, e);
            end
        end
        n_vec++;
        if (drop_cnt != base) begin
            n_bad++; $display("FAIL midreset_dropped: %0d pulses, required 0", drop_cnt - base);
        end
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    endtask

`ifdef UART_PACK_TIMEOUT_EN
    task automatic test_timeout();
        int            c;
        int            base;
        logic [WW-1:0] w;
        logic [WW-1:0] e;
        base     = drop_cnt;
        OutReady = 1'b1;
        for (int i = 0; i < 3; i++) send_byte(8'(8'h61 + i), c);
        idle(24);
        n_vec++;
        if (drop_cnt != base + 1) begin
            n_bad++; $display("FAIL timeout_pulses: %0d pulses, required 1", drop_cnt - base);
        end
        n_vec++;
        if (drop_cyc != c + 16) begin
            n_bad++; $display("FAIL timeout_time: pulse at cycle %0d, required %0d", drop_cyc, c + 16);
        end
        for (int i = 0; i < 8; i++) send_byte(8'(8'h21 + i), c);
        exp_q.push_back(64'h2827262524232221);
        idle(3);
        n_vec++;
        if (obs_q.size() != 1) begin
            n_bad++; $display("FAIL timeout_count: %0d words delivered, required 1", obs_q.size());
        end else begin
            w = obs_q.pop_front();
            e = exp_q.pop_front();
            n_vec++;
            if (w !== e) begin
                n_bad++; $display("FAIL timeout_word: got %h required %h", w, e);
            end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    endtask

    task automatic test_timeout_race();
        int            c;
        int            c_race;
        int            base;
        logic [WW-1:0] w;
        logic [WW-1:0] e;
        base     = drop_cnt;
        OutReady = 1'b1;
        for (int i = 0; i < 3; i++) send_byte(8'(8'h81 + i), c);
        InValid = 1'b0;
        for (int i = 0; i < 40 && cyc < c + 16; i++) tick();
        send_byte(8'h84, c_race);
        n_vec++;
        if (c_race != c + 16) begin
            n_bad++; $display("FAIL race_setup: byte accepted at cycle %0d, required %0d", c_race, c + 16);
        end
        for (int i = 0; i < 4; i++) send_byte(8'(8'h85 + i), c);
        exp_q.push_back(64'h8887868584838281);
        idle(3);
        n_vec++;
        if (drop_cnt != base) begin
            n_bad++; $display("FAIL race_dropped: %0d pulses, required 0", drop_cnt - base);
        end
        n_vec++;
        if (obs_q.size() != 1) begin
            n_bad++; $display("FAIL race_count: %0d words delivered, required 1", obs_q.size());
        end else begin
            w = obs_q.pop_front();
            e = exp_q.pop_front();
            n_vec++;
            if (w !== e) begin
                n_bad++; $display("FAIL race_word: got %h required %h", w, e);
            end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_word();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_word();
`ifdef UART_PACK_TIMEOUT_EN
        test_timeout();
        test_timeout_race();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
